alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control stage directly upstream of the 4-bit ALU.
- Accepts one 12-bit instruction per valid/ready handshake and reads operands from an internal 4x4-bit register file.
- Drives the ALU's one-hot control strobes and operands with the ALU's registered-output timing, captures the result and flags, and writes back to the register file.
- Strictly serialised: one instruction in flight.

Parameters:
- NREGS, 4, register file depth (register index width is log2(NREGS) = 2).
- DW, 4, datapath width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept; equals reset AND (state == IDLE).
- instr  in  12  [11:8] opcode, [7:6] rd, [5:4] rs1, [3:2] rs2, [3:0] imm (LDI only).
- alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh, alu_and, alu_or, alu_xor, alu_inv  out  1 each  one-hot ALU strobes.
- alu_in1, alu_in2  out  DW  ALU operands.
- alu_out  in  DW  registered ALU result.
- alu_overflow  in  1  ALU overflow/borrow.
- alu_shift_flag  in  1  combinational shifted-out bit.
- done  out  1  one-cycle pulse in the cycle the register file is written.
- illegal  out  1  one-cycle pulse on an illegal opcode.
- carry_flag, zero_flag, shift_flag  out  1 each  status flags.
- dbg_sel  in  2  debug register select.
- dbg_data  out  DW  combinational read of regfile[dbg_sel].

Behaviour:
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 INV, 7 LSH, 8 RSH, 9 LDI; 10-15 are illegal.
- Reset (reset low, asynchronous):
  - state=IDLE, all regfile entries 0.
  - All strobes, alu_in1/2, done, illegal and all flags are 0.
  - instr_ready is 0 while reset is low.
- Handshake: transfer occurs at a rising edge with instr_valid & instr_ready. At that edge op1=reg[rs1], op2=reg[rs2], opcode, rd and imm are latched. The instruction must be held while ready is low.
- FSM states: IDLE, ISSUE, SHLOAD, SHIFT, WB.
- Transitions from IDLE on transfer:
  - ADD/SUB/AND/OR/XOR/INV -> ISSUE.
  - LSH/RSH -> SHLOAD.
  - LDI -> WB.
  - NOP -> IDLE.
  - Illegal -> IDLE, with illegal=1 for the next cycle.
- ISSUE (1 cycle):
  - Exactly one strobe asserted; alu_in1=op1, alu_in2=op2.
  - The ALU registers its result at the ending edge. Next state WB.
- SHLOAD (1 cycle): alu_lsr=1, alu_in1=op1. The ALU shift register loads at the ending edge. Next state SHIFT.
- SHIFT (1 cycle):
  - alu_lsh or alu_rsh=1.
  - shift_flag <= alu_shift_flag at the ending edge.
  - carry_flag unchanged. Next state WB.
- WB (1 cycle):
  - done=1.
  - At the ending edge: reg[rd] <= (LDI ? imm : alu_out); zero_flag <= (written value == 0).
  - ADD/SUB: carry_flag <= alu_overflow. Logic ops: carry_flag <= 0. LDI: carry_flag unchanged.
  - Next state IDLE.
- Outside ISSUE/SHLOAD/SHIFT, all strobes are 0 and alu_in1/2 hold their last value.
- Latency (T = transfer edge cycle, done observed in):
  - ALU ops: T+2, next accept at T+3.
  - Shifts: T+3.
  - LDI: T+1.
- rd==rs is legal; operands are latched at transfer, so there is no hazard.
- No strobe is ever asserted for NOP, illegal or LDI.
- SUB carry_flag is the 5th bit of the 4-bit difference, i.e. the borrow.
- Reset mid-instruction aborts the instruction: no writeback, no done pulse, everything returns to reset values.

Decomposition:
- Shared package: opcode constants, state encoding, field bit positions, DW.
- One sub-module: alu_seq_regfile, with NREGS x DW storage, 2 synchronous-latched read ports used at transfer, 1 write port, 1 debug read port, and asynchronous active-low clear.

Test Plan:
- LDI r1,9; LDI r2,8.
  - Expected: done at T+1 each; dbg r1=9, r2=8; zero=0.
- ADD r3,r1,r2 (after the LDIs above).
  - Expected: alu_add high only at T+1 with in1=9, in2=8.
  - done at T+2; r3=1; carry=1; zero=0.
- SUB r0,r2,r1.
  - Expected: r0=F, carry=1.
- Follow-up ops.
  - XOR r0,r0,r0: r0=0, zero=1, carry=0.
- LSH r1,r1 with r1=9.
  - Expected: alu_lsr at T+1 only, alu_lsh at T+2 only, done at T+3.
  - r1=2, shift_flag=1, carry unchanged.
- Opcode F.
  - Expected: illegal pulse at T+1; no strobes; regfile unchanged; ready back high at T+1.
- Drop reset during SHLOAD, and hold instr_valid high during busy cycles.
  - Expected: all regs 0, no done, ready=0 while reset low.
  - With valid held, ready is 0 in ISSUE/SHLOAD/SHIFT/WB and no second transfer occurs.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU control sequencer.
// Instruction layout: [11:8] op, [7:6] rd, [5:4] rs1, [3:2] rs2, [3:0] imm.
package alu_sequencer_pkg;

  localparam int DW    = 4;
  localparam int NREGS = 4;
  localparam int AW    = $clog2(NREGS);
  localparam int IW    = 12;

  localparam int OP_LSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 2;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_INV = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_RSH = 4'd8;
  localparam logic [3:0] OP_LDI = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SHLOAD,
    S_SHIFT,
    S_WB
  } state_e;

  typedef struct packed {
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [1:0]    lo;
  } instr_t;

  function automatic logic op_is_alu(logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_INV);
  endfunction

  function automatic logic op_is_sh(logic [3:0] op);
    return (op == OP_LSH) || (op == OP_RSH);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU control/result and status bundle.
// slave = sequencer side, master = instruction source plus ALU.
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic          alu_add;
  logic          alu_sub;
  logic          alu_lsr;
  logic          alu_lsh;
  logic          alu_rsh;
  logic          alu_and;
  logic          alu_or;
  logic          alu_xor;
  logic          alu_inv;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [DW-1:0] alu_out;
  logic          alu_overflow;
  logic          alu_shift_flag;
  logic          done;
  logic          illegal;
  logic          carry_flag;
  logic          zero_flag;
  logic          shift_flag;

  modport slave (
    input  instr_valid, instr,
    input  alu_out, alu_overflow, alu_shift_flag,
    output instr_ready,
    output alu_add, alu_sub, alu_lsr, alu_lsh,
    output alu_rsh, alu_and, alu_or, alu_xor,
    output alu_inv, alu_in1, alu_in2,
    output done, illegal,
    output carry_flag, zero_flag, shift_flag
  );

  modport master (
    output instr_valid, instr,
    output alu_out, alu_overflow, alu_shift_flag,
    input  instr_ready,
    input  alu_add, alu_sub, alu_lsr, alu_lsh,
    input  alu_rsh, alu_and, alu_or, alu_xor,
    input  alu_inv, alu_in1, alu_in2,
    input  done, illegal,
    input  carry_flag, zero_flag, shift_flag
  );

endinterface

// File: rtl/alu_seq_regfile.sv
// NREGS x DW register file with two latched read ports,
// one write port and a combinational debug read port.
module alu_seq_regfile
  import alu_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          rd1_en_i,
  input  logic [AW-1:0] rs1_i,
  output logic [DW-1:0] rd1_o,
  input  logic          rd2_en_i,
  input  logic [AW-1:0] rs2_i,
  output logic [DW-1:0] rd2_o,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic [AW-1:0] dbg_sel_i,
  output logic [DW-1:0] dbg_o
);

  logic [DW-1:0] mem_q [NREGS];
  logic [DW-1:0] rd1_q;
  logic [DW-1:0] rd2_q;

  // Latched read data doubles as the held ALU operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      if (we_i) mem_q[wa_i] <= wd_i;
      if (rd1_en_i) rd1_q <= mem_q[rs1_i];
      if (rd2_en_i) rd2_q <= mem_q[rs2_i];
    end
  end

  assign rd1_o = rd1_q;
  assign rd2_o = rd2_q;
  assign dbg_o = mem_q[dbg_sel_i];

endmodule

// File: rtl/alu_sequencer.sv
// Serialising control stage in front of the 4-bit ALU:
// decodes, strobes the ALU, captures flags, writes back.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus,
  input  logic [AW-1:0]  dbg_sel,
  output logic [DW-1:0]  dbg_data
);

  state_e        state_q, state_d;
  instr_t        ins;
  logic [3:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] imm_q;
  logic          illegal_q;
  logic          carry_q;
  logic          zero_q;
  logic          shflag_q;
  logic          xfer;
  logic          is_alu;
  logic          is_sh;
  logic          is_ldi;
  logic          is_bad;
  logic          we;
  logic [DW-1:0] wdata;

  assign ins    = instr_t'(bus.instr);
  assign is_alu = op_is_alu(ins.op);
  assign is_sh  = op_is_sh(ins.op);
  assign is_ldi = (ins.op == OP_LDI);
  assign is_bad = (ins.op > OP_LDI);

  assign bus.instr_ready = reset & (state_q == S_IDLE);
  assign xfer  = bus.instr_valid & bus.instr_ready;
  assign we    = (state_q == S_WB);
  assign wdata = (op_q == OP_LDI) ? imm_q : bus.alu_out;

  alu_seq_regfile u_rf (
    .clk       (clk),
    .reset     (reset),
    .rd1_en_i  (xfer & (is_alu | is_sh)),
    .rs1_i     (ins.rs1),
    .rd1_o     (bus.alu_in1),
    .rd2_en_i  (xfer & is_alu),
    .rs2_i     (ins.rs2),
    .rd2_o     (bus.alu_in2),
    .we_i      (we),
    .wa_i      (rd_q),
    .wd_i      (wdata),
    .dbg_sel_i (dbg_sel),
    .dbg_o     (dbg_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      rd_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      shflag_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= xfer & is_bad;
      if (xfer) begin
        op_q  <= ins.op;
        rd_q  <= ins.rd;
        imm_q <= {ins.rs2, ins.lo};
      end
      if (state_q == S_SHIFT) begin
        shflag_q <= bus.alu_shift_flag;
      end
      if (we) begin
        zero_q <= (wdata == '0);
        // Shifts and LDI leave carry alone.
        unique case (op_q)
          OP_ADD, OP_SUB: carry_q <= bus.alu_overflow;
          OP_AND, OP_OR,
          OP_XOR, OP_INV: carry_q <= 1'b0;
          default:        carry_q <= carry_q;
        endcase
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bus.alu_add = 1'b0;
    bus.alu_sub = 1'b0;
    bus.alu_lsr = 1'b0;
    bus.alu_lsh = 1'b0;
    bus.alu_rsh = 1'b0;
    bus.alu_and = 1'b0;
    bus.alu_or  = 1'b0;
    bus.alu_xor = 1'b0;
    bus.alu_inv = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          unique case (1'b1)
            is_alu:  state_d = S_ISSUE;
            is_sh:   state_d = S_SHLOAD;
            is_ldi:  state_d = S_WB;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_ISSUE: begin
        state_d = S_WB;
        unique case (op_q)
          OP_ADD:  bus.alu_add = 1'b1;
          OP_SUB:  bus.alu_sub = 1'b1;
          OP_AND:  bus.alu_and = 1'b1;
          OP_OR:   bus.alu_or  = 1'b1;
          OP_XOR:  bus.alu_xor = 1'b1;
          OP_INV:  bus.alu_inv = 1'b1;
          default: ;
        endcase
      end
      S_SHLOAD: begin
        state_d     = S_SHIFT;
        bus.alu_lsr = 1'b1;
      end
      S_SHIFT: begin
        state_d     = S_WB;
        bus.alu_lsh = (op_q == OP_LSH);
        bus.alu_rsh = (op_q == OP_RSH);
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.done       = we;
  assign bus.illegal    = illegal_q;
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = zero_q;
  assign bus.shift_flag = shflag_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU
// and a scoreboard of expected writebacks, latencies and strobes.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: registered result, combinational shift-out bit.
  logic [3:0] m_out = 4'd0;
  logic       m_ov = 1'b0;
  logic [4:0] m_sum;
  logic [4:0] m_dif;

  assign m_sum = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
  assign m_dif = {1'b0, bus.alu_in1} - {1'b0, bus.alu_in2};

  always_ff @(posedge clk) begin
    if (bus.alu_add) {m_ov, m_out} <= m_sum;
    else if (bus.alu_sub) {m_ov, m_out} <= m_dif;
    else if (bus.alu_and) m_out <= bus.alu_in1 & bus.alu_in2;
    else if (bus.alu_or)  m_out <= bus.alu_in1 | bus.alu_in2;
    else if (bus.alu_xor) m_out <= bus.alu_in1 ^ bus.alu_in2;
    else if (bus.alu_inv) m_out <= ~bus.alu_in1;
    else if (bus.alu_lsr) m_out <= bus.alu_in1;
    else if (bus.alu_lsh) m_out <= {m_out[2:0], 1'b0};
    else if (bus.alu_rsh) m_out <= {1'b0, m_out[3:1]};
  end

  assign bus.alu_out        = m_out;
  assign bus.alu_overflow   = m_ov;
  assign bus.alu_shift_flag = bus.alu_lsh ? m_out[3] :
                              bus.alu_rsh ? m_out[0] : 1'b0;

  typedef struct {
    int              lat;
    logic [1:0]      rd;
    logic [3:0]      val;
    logic [3:0]      a;
    logic [3:0]      b;
    logic            c;
    logic            z;
    logic            s;
    logic            ill;
    logic [5:0][8:0] stb;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] rf[4];
  logic       rc, rz, rs;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] stb();
    return {bus.alu_add, bus.alu_sub, bus.alu_lsr,
            bus.alu_lsh, bus.alu_rsh, bus.alu_and,
            bus.alu_or, bus.alu_xor, bus.alu_inv};
  endfunction

  task automatic push(input logic [11:0] ins);
    exp_t       e;
    logic [3:0] op;
    logic [4:0] r;
    op    = ins[11:8];
    e.rd  = ins[7:6];
    e.a   = rf[ins[5:4]];
    e.b   = rf[ins[3:2]];
    e.c   = rc;
    e.s   = rs;
    e.ill = (op >= 4'd10);
    e.lat = 0;
    e.val = 4'd0;
    e.stb = '0;
    r     = 5'd0;
    case (op)
      4'd1: begin
        r = {1'b0, e.a} + {1'b0, e.b};
        e.val = r[3:0]; e.c = r[4];
        e.stb[1] = 9'h100; e.lat = 2;
      end
      4'd2: begin
        r = {1'b0, e.a} - {1'b0, e.b};
        e.val = r[3:0]; e.c = r[4];
        e.stb[1] = 9'h080; e.lat = 2;
      end
      4'd3: begin
        e.val = e.a & e.b; e.c = 1'b0;
        e.stb[1] = 9'h008; e.lat = 2;
      end
      4'd4: begin
        e.val = e.a | e.b; e.c = 1'b0;
        e.stb[1] = 9'h004; e.lat = 2;
      end
      4'd5: begin
        e.val = e.a ^ e.b; e.c = 1'b0;
        e.stb[1] = 9'h002; e.lat = 2;
      end
      4'd6: begin
        e.val = ~e.a; e.c = 1'b0;
        e.stb[1] = 9'h001; e.lat = 2;
      end
      4'd7: begin
        e.val = {e.a[2:0], 1'b0}; e.s = e.a[3];
        e.stb[1] = 9'h040; e.stb[2] = 9'h020; e.lat = 3;
      end
      4'd8: begin
        e.val = {1'b0, e.a[3:1]}; e.s = e.a[0];
        e.stb[1] = 9'h040; e.stb[2] = 9'h010; e.lat = 3;
      end
      4'd9: begin
        e.val = ins[3:0]; e.lat = 1;
      end
      default: ;
    endcase
    if (e.lat != 0) begin
      rf[e.rd] = e.val;
      rc = e.c;
      rs = e.s;
      rz = (e.val == 4'd0);
    end
    e.z = rz;
    sb.push_back(e);
  endtask

  // Holds valid for the whole instruction to prove no double transfer.
  task automatic run(input string tag, input logic [11:0] ins);
    exp_t e;
    int   n;
    push(ins);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    chk({tag, ":rdy0"}, 16'(bus.instr_ready), 16'd1);
    @(posedge clk); #1;
    if (sb[0].lat == 0) begin
      bus.instr_valid = 1'b0;
      e = sb.pop_front();
      chk({tag, ":ill"}, 16'(bus.illegal), 16'(e.ill));
      chk({tag, ":stb"}, 16'(stb()), 16'd0);
      chk({tag, ":done"}, 16'(bus.done), 16'd0);
      chk({tag, ":rdy"}, 16'(bus.instr_ready), 16'd1);
      chk({tag, ":c"}, 16'(bus.carry_flag), 16'(e.c));
      return;
    end
    n = 1;
    while (!bus.done && n < 5) begin
      chk({tag, ":stb"}, 16'(stb()), 16'(sb[0].stb[n]));
      chk({tag, ":busy"}, 16'(bus.instr_ready), 16'd0);
      if (n == 1) begin
        chk({tag, ":in1"}, 16'(bus.alu_in1), 16'(sb[0].a));
        if (sb[0].lat == 2)
          chk({tag, ":in2"}, 16'(bus.alu_in2), 16'(sb[0].b));
      end
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk({tag, ":lat"}, 16'(n), 16'(e.lat));
    chk({tag, ":wbstb"}, 16'(stb()), 16'd0);
    chk({tag, ":wbrdy"}, 16'(bus.instr_ready), 16'd0);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    chk({tag, ":dn1"}, 16'(bus.done), 16'd0);
    dbg_sel = e.rd;
    #1;
    chk({tag, ":val"}, 16'(dbg_data), 16'(e.val));
    chk({tag, ":c"}, 16'(bus.carry_flag), 16'(e.c));
    chk({tag, ":z"}, 16'(bus.zero_flag), 16'(e.z));
    chk({tag, ":s"}, 16'(bus.shift_flag), 16'(e.s));
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("%s:r%0d", tag, i), 16'(dbg_data), 16'(rf[i]));
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ":rdy"}, 16'(bus.instr_ready), 16'd0);
    chk({tag, ":done"}, 16'(bus.done), 16'd0);
    chk({tag, ":ill"}, 16'(bus.illegal), 16'd0);
    chk({tag, ":stb"}, 16'(stb()), 16'd0);
    chk({tag, ":ops"}, {8'd0, bus.alu_in1, bus.alu_in2}, 16'd0);
    chk({tag, ":flg"}, 16'({bus.carry_flag, bus.zero_flag,
                            bus.shift_flag}), 16'd0);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    dbg_sel         = 2'd0;
    for (int i = 0; i < 4; i++) rf[i] = 4'd0;
    rc = 1'b0; rz = 1'b0; rs = 1'b0;

    #1;
    chk_rst("rst");
    chk_regs("rst");
    #21 reset = 1'b1;
    @(posedge clk); #1;

    run("ldi_r1", 12'h949);
    run("ldi_r2", 12'h988);
    run("add_r3", 12'h1D8);
    run("sub_r0", 12'h224);
    run("xor_r0", 12'h500);
    run("add_r2", 12'h194);
    run("lsh_r1", 12'h750);
    run("rsh_r3", 12'h8F0);
    run("and_r0", 12'h318);
    run("or_r3",  12'h4D0);
    run("inv_r2", 12'h6A0);
    run("nop",    12'h0FF);
    run("ill_f",  12'hFD5);
    chk_regs("ill_f");
    run("ill_a",  12'hA00);

    // Abort a shift while it sits in SHLOAD.
    bus.instr       = 12'h750;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    chk("mid:shload", 16'(stb()), 16'h040);
    #2 reset = 1'b0;
    #1;
    chk_rst("mid");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("mid:nodone", 16'(bus.done), 16'd0);
      chk("mid:norrdy", 16'(bus.instr_ready), 16'd0);
    end
    for (int i = 0; i < 4; i++) rf[i] = 4'd0;
    rc = 1'b0; rz = 1'b0; rs = 1'b0;
    chk_regs("mid");
    bus.instr_valid = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("post:rdy", 16'(bus.instr_ready), 16'd1);
    run("ldi_r3", 12'h9C5);
    chk_regs("end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
